// File: rtl/nz_addr_serializer_if.sv
// Group-in / beat-out handshake bundle for the non-zero address serializer.
// The master side feeds address groups and consumes beats. The slave side is the serializer.
interface nz_addr_serializer_if #(
    parameter int unsigned DIM        = 5,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned CNT_WIDTH  = 3
);
    logic                      in_valid;
    logic                      in_ready;
    logic [ADDR_WIDTH*DIM-1:0] in_addr_bus;
    logic [CNT_WIDTH-1:0]      in_count;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [ADDR_WIDTH-1:0]     out_addr;
    logic                      out_last;
    logic                      out_null;
    logic [ADDR_WIDTH:0]       out_nnz;
    logic                      err;

    modport master (
        output in_valid, in_addr_bus, in_count, in_last, out_ready,
        input  in_ready, out_valid, out_addr, out_last, out_null, out_nnz, err
    );

    modport slave (
        input  in_valid, in_addr_bus, in_count, in_last, out_ready,
        output in_ready, out_valid, out_addr, out_last, out_null, out_nnz, err
    );
endinterface

// File: rtl/nz_addr_serializer.sv
// Buffers one group of up to DIM non-zero addresses and emits them one per cycle.
// It flags the last beat of each feature vector and reports that vector's non-zero count.
module nz_addr_serializer #(
    parameter int unsigned DIM        = 5,
    parameter int unsigned SPAD_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = $clog2(SPAD_WIDTH),
    parameter int unsigned CNT_WIDTH  = $clog2(DIM + 1)
) (
    input logic                 clk,
    input logic                 reset,
    nz_addr_serializer_if.slave bus
);
    localparam int unsigned NnzWidth = ADDR_WIDTH + 1;

    localparam logic [0:0] StEmpty = 1'b0;
    localparam logic [0:0] StDrain = 1'b1;

    localparam logic [CNT_WIDTH-1:0] DimCnt = CNT_WIDTH'(DIM);
    localparam logic [NnzWidth-1:0]  NnzMax = '1;

    logic [0:0]                state_q, state_d;
    logic [ADDR_WIDTH*DIM-1:0] grp_q, grp_d;
    logic [CNT_WIDTH-1:0]      rem_q, rem_d;
    logic [CNT_WIDTH-1:0]      idx_q, idx_d;
    logic                      last_q, last_d;
    logic                      null_q, null_d;
    logic                      err_q, err_d;
    logic [NnzWidth-1:0]       vcnt_q, vcnt_d;

    logic                      out_valid;
    logic                      beat_fire;
    logic                      group_end;
    logic                      vec_end;
    logic                      in_ready;
    logic                      accept;
    logic                      over;
    logic [CNT_WIDTH-1:0]      cnt_clamped;
    logic [NnzWidth-1:0]       vcnt_inc;
    logic [ADDR_WIDTH-1:0]     cur_addr;

    // Slot 0 sits at the MSB end of the packed group.
    always_comb begin
        cur_addr = '0;
        for (int unsigned k = 0; k < DIM; k++) begin
            if (idx_q == CNT_WIDTH'(k)) begin
                cur_addr = grp_q[ADDR_WIDTH*(DIM-k)-1 -: ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        out_valid   = (state_q == StDrain);
        beat_fire   = out_valid && bus.out_ready;
        group_end   = null_q || (rem_q == CNT_WIDTH'(1));
        vec_end     = null_q || (last_q && (rem_q == CNT_WIDTH'(1)));
        // Accept on the final beat's edge too, so groups stream with no bubble.
        in_ready    = (state_q == StEmpty) || (beat_fire && group_end);
        accept      = bus.in_valid && in_ready;
        over        = (bus.in_count > DimCnt);
        cnt_clamped = over ? DimCnt : bus.in_count;
        vcnt_inc    = (vcnt_q == NnzMax) ? vcnt_q : vcnt_q + NnzWidth'(1);
    end

    always_comb begin
        bus.in_ready  = in_ready;
        bus.out_valid = out_valid;
        bus.out_addr  = (out_valid && !null_q) ? cur_addr : '0;
        bus.out_last  = out_valid && vec_end;
        bus.out_null  = out_valid && null_q;
        bus.out_nnz   = !out_valid ? '0 : (null_q ? vcnt_q : vcnt_inc);
        bus.err       = err_q;
    end

    always_comb begin
        grp_d  = grp_q;
        rem_d  = rem_q;
        idx_d  = idx_q;
        last_d = last_q;
        null_d = null_q;
        err_d  = err_q;
        vcnt_d = vcnt_q;

        if (beat_fire) begin
            if (null_q) begin
                null_d = 1'b0;
            end else begin
                idx_d  = idx_q + CNT_WIDTH'(1);
                rem_d  = rem_q - CNT_WIDTH'(1);
                vcnt_d = vcnt_inc;
            end
            if (vec_end) begin
                vcnt_d = '0;
            end
        end

        // A departing beat's vcnt update above is kept; the new group only reloads the buffer.
        if (accept) begin
            grp_d  = bus.in_addr_bus;
            rem_d  = cnt_clamped;
            idx_d  = '0;
            last_d = bus.in_last;
            null_d = (cnt_clamped == '0) && bus.in_last;
            if (over) begin
                err_d = 1'b1;
            end
        end

        state_d = ((rem_d != '0) || null_d) ? StDrain : StEmpty;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StEmpty;
            grp_q   <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            null_q  <= 1'b0;
            err_q   <= 1'b0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            null_q  <= null_d;
            err_q   <= err_d;
            vcnt_q  <= vcnt_d;
        end
    end
endmodule

// File: tb/tb_nz_addr_serializer.sv
// Scoreboard bench for nz_addr_serializer: expected beats are queued as groups are issued
// and popped as the serializer hands beats to the consumer.
module tb_nz_addr_serializer;
    localparam int unsigned DIM = 5;
    localparam int unsigned AW  = 6;
    localparam int unsigned CW  = 3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          last;
        logic          nul;
        logic [AW:0]   nnz;
    } beat_t;

    logic  clk = 1'b0;
    logic  reset;
    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];

    nz_addr_serializer_if #(.DIM(DIM), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    nz_addr_serializer #(
        .DIM        (DIM),
        .SPAD_WIDTH (64),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic beat_t sample_beat();
        beat_t b;
        b.addr = bus.out_addr;
        b.last = bus.out_last;
        b.nul  = bus.out_null;
        b.nnz  = bus.out_nnz;
        return b;
    endfunction

    task automatic push(input logic [AW-1:0] a, input logic l, input logic n, input logic [AW:0] c);
        beat_t b;
        b.addr = a;
        b.last = l;
        b.nul  = n;
        b.nnz  = c;
        exp_q.push_back(b);
    endtask

    // Presents a group at a negedge and returns right after the edge that accepts it.
    task automatic send_group(input logic [AW*DIM-1:0] addrs, input logic [CW-1:0] cnt,
                              input logic last);
        bit done = 1'b0;
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.in_addr_bus = addrs;
        bus.in_count    = cnt;
        bus.in_last     = last;
        for (int c = 0; c < 50; c++) begin
            #1;
            done = bus.in_ready;
            @(posedge clk);
            if (done) break;
            @(negedge clk);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL accept_timeout got in_ready=0 for 50 cycles want 1");
        end
    endtask

    task automatic test_reset();
        reset           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_addr_bus = '0;
        bus.in_count    = '0;
        bus.in_last     = 1'b0;
        bus.out_ready   = 1'b1;
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_addr !== '0) begin errors++;
            $display("FAIL reset_out_addr got %0d want 0", bus.out_addr); end
        checks++; if (bus.out_last !== 1'b0 || bus.out_null !== 1'b0) begin errors++;
            $display("FAIL reset_flags got last=%b null=%b want 0 0", bus.out_last, bus.out_null); end
        checks++; if (bus.out_nnz !== '0) begin errors++;
            $display("FAIL reset_out_nnz got %0d want 0", bus.out_nnz); end
        checks++; if (bus.err !== 1'b0) begin errors++;
            $display("FAIL reset_err got %b want 0", bus.err); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [AW-1:0] a [5];
        int cyc = 0, first = -1, lastc = -1;
        beat_t g, e;
        a = '{6'd3, 6'd9, 6'd17, 6'd40, 6'd63};
        for (int i = 0; i < 5; i++) push(a[i], i == 4, 1'b0, 7'(i + 1));
        fork
            begin
                send_group({6'd3, 6'd9, 6'd17, 6'd40, 6'd63}, 3'd5, 1'b1);
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            begin
                while (exp_q.size() > 0 && cyc < 40) begin
                    @(negedge clk); #1;
                    if (bus.out_valid && bus.out_ready) begin
                        e = exp_q.pop_front();
                        g = sample_beat();
                        checks++; if (g !== e) begin errors++;
                            $display("FAIL single_beat got a=%0d l=%b n=%b nnz=%0d want a=%0d l=%b n=%b nnz=%0d",
                                     g.addr, g.last, g.nul, g.nnz, e.addr, e.last, e.nul, e.nnz); end
                        checks++; if (bus.in_ready !== e.last) begin errors++;
                            $display("FAIL single_in_ready got %b want %b", bus.in_ready, e.last); end
                        if (first < 0) first = cyc;
                        lastc = cyc;
                    end
                    cyc++;
                end
            end
        join
        checks++;
        if (exp_q.size() != 0 || lastc - first + 1 != 5) begin errors++;
            $display("FAIL single_span got %0d cycles (%0d left) want 5", lastc - first + 1, exp_q.size()); end
    endtask

    task automatic test_chain();
        logic [AW-1:0] a [7];
        int cyc = 0, first = -1, lastc = -1;
        beat_t g, e;
        a = '{6'd1, 6'd2, 6'd5, 6'd7, 6'd8, 6'd12, 6'd30};
        for (int i = 0; i < 7; i++) push(a[i], i == 6, 1'b0, 7'(i + 1));
        fork
            begin
                send_group({6'd1, 6'd2, 6'd5, 6'd7, 6'd8}, 3'd5, 1'b0);
                send_group({6'd12, 6'd30, 6'd50, 6'd51, 6'd52}, 3'd2, 1'b1);
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            begin
                while (exp_q.size() > 0 && cyc < 40) begin
                    @(negedge clk); #1;
                    if (bus.out_valid && bus.out_ready) begin
                        e = exp_q.pop_front();
                        g = sample_beat();
                        checks++; if (g !== e) begin errors++;
                            $display("FAIL chain_beat got a=%0d l=%b n=%b nnz=%0d want a=%0d l=%b n=%b nnz=%0d",
                                     g.addr, g.last, g.nul, g.nnz, e.addr, e.last, e.nul, e.nnz); end
                        if (first < 0) first = cyc;
                        lastc = cyc;
                    end
                    cyc++;
                end
            end
        join
        checks++;
        if (exp_q.size() != 0 || lastc - first + 1 != 7) begin errors++;
            $display("FAIL chain_span got %0d cycles (%0d left) want 7", lastc - first + 1, exp_q.size()); end
        @(negedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++;
            $display("FAIL chain_extra_beat got out_valid=%b addr=%0d want 0", bus.out_valid, bus.out_addr); end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] a [5];
        int cyc = 0, first = -1, lastc = -1, nb = 0, stalls = 0;
        beat_t g, e;
        a = '{6'd10, 6'd20, 6'd30, 6'd40, 6'd50};
        for (int i = 0; i < 5; i++) push(a[i], i == 4, 1'b0, 7'(i + 1));
        fork
            begin
                send_group({6'd10, 6'd20, 6'd30, 6'd40, 6'd50}, 3'd5, 1'b1);
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            begin
                while (exp_q.size() > 0 && cyc < 40) begin
                    @(negedge clk);
                    bus.out_ready = !(nb == 1 && stalls < 2);
                    #1;
                    if (bus.out_valid && !bus.out_ready) begin
                        stalls++;
                        checks++; if (bus.out_addr !== exp_q[0].addr || bus.in_ready !== 1'b0) begin
                            errors++;
                            $display("FAIL bp_hold got addr=%0d in_ready=%b want addr=%0d in_ready=0",
                                     bus.out_addr, bus.in_ready, exp_q[0].addr); end
                    end else if (bus.out_valid) begin
                        e = exp_q.pop_front();
                        g = sample_beat();
                        checks++; if (g !== e) begin errors++;
                            $display("FAIL bp_beat got a=%0d l=%b n=%b nnz=%0d want a=%0d l=%b n=%b nnz=%0d",
                                     g.addr, g.last, g.nul, g.nnz, e.addr, e.last, e.nul, e.nnz); end
                        checks++; if (bus.in_ready !== e.last) begin errors++;
                            $display("FAIL bp_in_ready got %b want %b", bus.in_ready, e.last); end
                        if (first < 0) first = cyc;
                        lastc = cyc;
                        nb++;
                    end
                    cyc++;
                end
            end
        join
        bus.out_ready = 1'b1;
        checks++;
        if (exp_q.size() != 0 || nb != 5 || lastc - first + 1 != 7) begin errors++;
            $display("FAIL bp_span got beats=%0d cycles=%0d want beats=5 cycles=7", nb, lastc - first + 1); end
    endtask

    task automatic test_empty();
        int cyc = 0;
        beat_t g, e;
        push(6'd0, 1'b1, 1'b1, 7'd0);
        push(6'd5, 1'b0, 1'b0, 7'd1);
        push(6'd6, 1'b0, 1'b0, 7'd2);
        push(6'd0, 1'b1, 1'b1, 7'd2);
        fork
            begin
                send_group('0, 3'd0, 1'b1);
                @(negedge clk);
                bus.in_valid = 1'b0;
                // A zero-count, non-last group must be swallowed silently.
                send_group({6'd33, 6'd34, 6'd35, 6'd36, 6'd37}, 3'd0, 1'b0);
                @(negedge clk);
                bus.in_valid = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    #1;
                    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++;
                        $display("FAIL empty_absorb got out_valid=%b in_ready=%b want 0 1",
                                 bus.out_valid, bus.in_ready); end
                    @(negedge clk);
                end
                send_group({6'd5, 6'd6, 6'd0, 6'd0, 6'd0}, 3'd2, 1'b0);
                send_group('0, 3'd0, 1'b1);
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            begin
                while (exp_q.size() > 0 && cyc < 60) begin
                    @(negedge clk); #1;
                    if (bus.out_valid && bus.out_ready) begin
                        e = exp_q.pop_front();
                        g = sample_beat();
                        checks++; if (g !== e) begin errors++;
                            $display("FAIL empty_beat got a=%0d l=%b n=%b nnz=%0d want a=%0d l=%b n=%b nnz=%0d",
                                     g.addr, g.last, g.nul, g.nnz, e.addr, e.last, e.nul, e.nnz); end
                    end
                    cyc++;
                end
            end
        join
        checks++; if (exp_q.size() != 0) begin errors++;
            $display("FAIL empty_timeout got %0d beats missing want 0", exp_q.size()); end
    endtask

    task automatic test_clamp();
        int cyc = 0, nb = 0;
        beat_t g, e;
        for (int i = 0; i < 5; i++) push(6'(i + 1), i == 4, 1'b0, 7'(i + 1));
        push(6'd6, 1'b1, 1'b0, 7'd1);
        fork
            begin
                send_group({6'd1, 6'd2, 6'd3, 6'd4, 6'd5}, 3'd7, 1'b1);
                @(negedge clk);
                bus.in_valid = 1'b0;
                #1;
                checks++; if (bus.err !== 1'b1) begin errors++;
                    $display("FAIL clamp_err_set got %b want 1", bus.err); end
                wait (exp_q.size() == 1 || cyc >= 40);
                send_group({6'd6, 6'd0, 6'd0, 6'd0, 6'd0}, 3'd1, 1'b1);
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            begin
                while (exp_q.size() > 0 && cyc < 40) begin
                    @(negedge clk); #1;
                    if (bus.out_valid && bus.out_ready) begin
                        e = exp_q.pop_front();
                        g = sample_beat();
                        nb++;
                        checks++; if (g !== e) begin errors++;
                            $display("FAIL clamp_beat got a=%0d l=%b n=%b nnz=%0d want a=%0d l=%b n=%b nnz=%0d",
                                     g.addr, g.last, g.nul, g.nnz, e.addr, e.last, e.nul, e.nnz); end
                    end
                    cyc++;
                end
            end
        join
        checks++; if (exp_q.size() != 0 || nb != 6) begin errors++;
            $display("FAIL clamp_count got %0d beats want 6", nb); end
        checks++; if (bus.err !== 1'b1) begin errors++;
            $display("FAIL clamp_err_sticky got %b want 1", bus.err); end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        beat_t g, e;
        send_group({6'd11, 6'd22, 6'd33, 6'd44, 6'd55}, 3'd5, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_addr !== 6'd11) begin errors++;
            $display("FAIL rmid_beat0 got %0d want 11", bus.out_addr); end
        @(negedge clk); #1;
        checks++; if (bus.out_addr !== 6'd22) begin errors++;
            $display("FAIL rmid_beat1 got %0d want 22", bus.out_addr); end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL rmid_reset got out_valid=%b in_ready=%b err=%b want 0 1 0",
                     bus.out_valid, bus.in_ready, bus.err); end
        @(negedge clk);
        reset = 1'b0;
        push(6'd4, 1'b1, 1'b0, 7'd1);
        fork
            begin
                send_group({6'd4, 6'd0, 6'd0, 6'd0, 6'd0}, 3'd1, 1'b1);
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            begin
                while (exp_q.size() > 0 && cyc < 40) begin
                    @(negedge clk); #1;
                    if (bus.out_valid && bus.out_ready) begin
                        e = exp_q.pop_front();
                        g = sample_beat();
                        checks++; if (g !== e) begin errors++;
                            $display("FAIL rmid_beat got a=%0d l=%b n=%b nnz=%0d want a=%0d l=%b n=%b nnz=%0d",
                                     g.addr, g.last, g.nul, g.nnz, e.addr, e.last, e.nul, e.nnz); end
                    end
                    cyc++;
                end
            end
        join
        checks++; if (exp_q.size() != 0) begin errors++;
            $display("FAIL rmid_timeout got %0d beats missing want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_chain();
        test_backpressure();
        test_empty();
        test_clamp();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
